// File: rtl/cluster_clock_pkg.sv
// Shared types and helpers for the cluster clock divider.
package cluster_clock_pkg;

  localparam int unsigned DIV_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ratios below 2 cannot produce a high and a low phase, so they become 2.
  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < 2) ? 2 : n;
  endfunction

endpackage

// File: rtl/cluster_clock_divider.sv
// Programmable integer clock divider with period-boundary ratio change and
// enable/disable, plus a scan bypass at the output.
module cluster_clock_divider
  import cluster_clock_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int unsigned DIV_INIT  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 test_mode_i,
  input  logic                 div_valid_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 div_ready_o,
  output logic                 clk_o,
  output logic                 running_o
);

  typedef logic [DIV_WIDTH-1:0] div_t;
  typedef logic [DIV_WIDTH:0]   half_t;

  localparam div_t  DIV_ONE  = div_t'(1);
  localparam half_t HALF_ONE = half_t'(1);

  // High-phase length; one bit wider so the maximum ratio cannot overflow.
  function automatic half_t half_ceil(input div_t n);
    return ({1'b0, n} + HALF_ONE) >> 1;
  endfunction

  state_t state_q, state_d;
  div_t   cnt_q, cnt_d;
  div_t   div_q, div_d;
  div_t   pend_div_q, pend_div_d;
  logic   pend_q, pend_d;
  logic   clk_q, clk_d;

  logic   boundary;
  logic   apply;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= div_t'(DIV_INIT);
      pend_q     <= 1'b0;
      pend_div_q <= div_t'(DIV_INIT);
      clk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      clk_q      <= clk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    clk_d      = clk_q;

    boundary = (state_q == RUN) && (cnt_q == (div_q - DIV_ONE));
    apply    = pend_q && ((state_q == IDLE) || boundary);

    // Apply needs pend_q set and a transfer needs it clear, so the two never
    // collide; a transfer on a boundary edge therefore waits a full period.
    if (apply) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end else if (div_valid_i && !pend_q) begin
      pend_d     = 1'b1;
      pend_div_d = div_t'(clamp_div(32'(div_i)));
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
        end
      end
      RUN: begin
        if (boundary) begin
          cnt_d = '0;
          if (en_i) begin
            clk_d = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_ONE;
          clk_d = ({1'b0, cnt_d} < half_ceil(div_d));
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  assign div_ready_o = !pend_q;
  assign running_o   = (state_q == RUN);
  assign clk_o       = test_mode_i ? clk_i : clk_q;

endmodule

// File: tb/tb_cluster_clock_divider.sv
// Directed bench for cluster_clock_divider: expected clk_o samples are queued
// per period shape and popped one per reference edge.
module tb_cluster_clock_divider;

  logic       clk;
  logic       rst;
  logic       en;
  logic       test_mode;
  logic       div_valid;
  logic [7:0] div;
  logic       div_ready;
  logic       clk_out;
  logic       running;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  cluster_clock_divider #(.DIV_WIDTH(8), .DIV_INIT(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .test_mode_i (test_mode),
    .div_valid_i (div_valid),
    .div_i       (div),
    .div_ready_o (div_ready),
    .clk_o       (clk_out),
    .running_o   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_period(input int h, input int l, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < h; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < l; i++) exp_q.push_back(1'b0);
    end
  endtask

  task automatic push_low(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
  endtask

  // One reference edge per iteration; clk_o compared 1 time unit after it.
  task automatic step(input int n, input string tag);
    logic e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s: observed=%0b expected=<queue empty>", tag, clk_out);
      end else begin
        e = exp_q.pop_front();
        check(tag, {31'd0, clk_out}, {31'd0, e});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; test_mode = 1'b0; div_valid = 1'b0; div = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk", {31'd0, clk_out}, 32'd0);
    check("rst_ready", {31'd0, div_ready}, 32'd1);
    check("rst_running", {31'd0, running}, 32'd0);

    // N=2 after enable
    rst = 1'b0; en = 1'b1;
    push_period(1, 1, 4);
    step(1, "n2_first");
    check("n2_running", {31'd0, running}, 32'd1);
    check("n2_ready", {31'd0, div_ready}, 32'd1);
    step(7, "n2");

    // Transfer on boundary edge, second offer while pending is ignored
    div_valid = 1'b1; div = 8'd4;
    push_period(1, 1, 1);
    step(1, "bnd_xfer");
    check("bnd_ready0", {31'd0, div_ready}, 32'd0);
    div = 8'd7;
    step(1, "bnd_hold");
    check("bnd_ready1", {31'd0, div_ready}, 32'd0);
    div_valid = 1'b0;
    push_period(2, 2, 2);
    step(1, "n4_first");
    check("n4_ready", {31'd0, div_ready}, 32'd1);
    step(7, "n4");

    // Mid-period change 4 -> 5
    push_period(2, 2, 1);
    step(2, "n4_tail");
    div_valid = 1'b1; div = 8'd5;
    step(1, "mid_xfer");
    check("mid_ready0", {31'd0, div_ready}, 32'd0);
    div_valid = 1'b0;
    step(1, "mid_wait");
    check("mid_ready1", {31'd0, div_ready}, 32'd0);
    push_period(3, 2, 2);
    step(1, "n5_first");
    check("n5_ready", {31'd0, div_ready}, 32'd1);
    step(9, "n5");

    // div_i = 0 clamps to 2
    push_period(3, 2, 1);
    step(1, "n5_tail");
    div_valid = 1'b1; div = 8'd0;
    step(1, "d0_xfer");
    div_valid = 1'b0;
    step(3, "d0_wait");
    push_period(1, 1, 3);
    step(6, "d0_as_n2");

    // div_i = 1 clamps to 2
    div_valid = 1'b1; div = 8'd1;
    push_period(1, 1, 2);
    step(1, "d1_xfer");
    check("d1_ready0", {31'd0, div_ready}, 32'd0);
    div_valid = 1'b0;
    step(3, "d1_as_n2");
    check("d1_ready1", {31'd0, div_ready}, 32'd1);

    // div_i = 255: 128 high, 127 low; N=6 transferred mid-period
    div_valid = 1'b1; div = 8'd255;
    push_period(1, 1, 1);
    step(1, "d255_xfer");
    div_valid = 1'b0;
    step(1, "d255_wait");
    push_period(128, 127, 1);
    step(10, "n255_a");
    div_valid = 1'b1; div = 8'd6;
    step(1, "n255_xfer6");
    div_valid = 1'b0;
    step(244, "n255_b");

    // N=6, en dropped at cnt=1: period completes then IDLE
    push_period(3, 3, 2);
    step(6, "n6");
    step(2, "n6_pre_drop");
    en = 1'b0;
    step(4, "n6_drain");
    push_low(4);
    step(1, "idle_first");
    check("idle_running", {31'd0, running}, 32'd0);
    step(3, "idle");

    // One-cycle en low pulse mid-period has no effect
    en = 1'b1;
    push_period(3, 3, 2);
    step(2, "pulse_pre");
    en = 1'b0;
    step(1, "pulse_low");
    en = 1'b1;
    step(3, "pulse_post");
    check("pulse_running", {31'd0, running}, 32'd1);
    step(6, "pulse_next");

    // Async reset while clk_o is high, with a ratio pending
    div_valid = 1'b1; div = 8'd9;
    push_period(1, 0, 1);
    step(1, "prerst_high");
    check("prerst_ready", {31'd0, div_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("arst_clk", {31'd0, clk_out}, 32'd0);
    check("arst_running", {31'd0, running}, 32'd0);
    check("arst_ready", {31'd0, div_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0; div_valid = 1'b0;
    push_period(1, 1, 2);
    step(4, "postrst_n2");

    // Test-mode bypass; divider keeps running underneath
    test_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("tm_high", {31'd0, clk_out}, 32'd1);
      @(negedge clk);
      #1;
      check("tm_low", {31'd0, clk_out}, 32'd0);
    end
    check("tm_running", {31'd0, running}, 32'd1);
    @(posedge clk);
    #1;
    test_mode = 1'b0;
    exp_q.push_back(1'b0);
    push_period(1, 1, 1);
    step(3, "tm_resume");

    // Disable, then ratio applied on the same edge as enable from IDLE
    en = 1'b0;
    push_low(2);
    step(2, "dis");
    check("dis_running", {31'd0, running}, 32'd0);
    div_valid = 1'b1; div = 8'd3;
    push_low(1);
    step(1, "idle_xfer");
    div_valid = 1'b0;
    check("idle_ready0", {31'd0, div_ready}, 32'd0);
    en = 1'b1;
    push_period(2, 1, 2);
    step(1, "n3_first");
    check("n3_ready", {31'd0, div_ready}, 32'd1);
    step(5, "n3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cluster_clock_divider.md
# cluster_clock_divider

Programmable integer clock divider that generates the divided cluster clock. It feeds the slow-clock input of the cluster's glitchless 2:1 clock mux. A single counter/FSM produces a registered output clock. The divide ratio is changed through a valid/ready handshake and takes effect only at a period boundary. Enable and disable also act only at a period boundary, so the output never produces a runt pulse in functional mode.

## Interface
- DIV_WIDTH, 8: width of the divide-ratio field.
- DIV_INIT, 2: divide ratio loaded at reset; must be >= 2.
- clk_i  in  1  reference clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  request divided-clock output (level).
- test_mode_i  in  1  scan bypass: clk_o = clk_i combinationally.
- div_valid_i  in  1  new divide ratio offered.
- div_i  in  DIV_WIDTH  new divide ratio N; values 0 and 1 are clamped to 2.
- div_ready_o  out  1  divider can accept a new ratio.
- clk_o  out  1  divided clock (registered clk_q except in test mode).
- running_o  out  1  FSM is in RUN.

## Operation
- State registers:
  - FSM {IDLE, RUN}
  - cnt_q [DIV_WIDTH]
  - div_q [DIV_WIDTH] (active N)
  - pend_q, pend_div_q (pending ratio)
  - clk_q
- Reset values: FSM=IDLE, cnt_q=0, div_q=DIV_INIT, pend_q=0, clk_q=0. Resulting outputs: clk_o=0 (test_mode_i=0), div_ready_o=1, running_o=0.
- Derived quantities: H = ceil(N/2). In RUN, clk_q=1 while cnt_q < H, otherwise 0. High time is H cycles; low time is N−H cycles. For odd N the duty cycle is not 50%.
- Handshake:
  - div_ready_o = !pend_q.
  - Transfer occurs on an edge with div_valid_i && div_ready_o. It sets pend_q=1 and pend_div_q=clamp(div_i).
  - While pend_q=1, div_valid_i is ignored. The upstream side must hold div_i stable until the transfer.
- Apply: the pending ratio is copied into div_q, and pend_q is cleared, on the first edge after the transfer where FSM=IDLE or (RUN and cnt_q==div_q−1).
  - A transfer on a boundary edge is never applied on that same edge. It is applied at the next boundary.
- IDLE:
  - cnt_q=0, clk_q=0.
  - An edge with en_i=1 moves to RUN, keeps cnt_q=0 and sets clk_q=1.
  - If a pending ratio is applied on that same edge, the new N is used from this first period onward.
- RUN:
  - cnt_q increments each edge and wraps from N−1 to 0.
  - clk_q is loaded with (cnt_next < H_next), where H_next is taken from the div_q value in effect after the edge.
- Disable: en_i is sampled only at the boundary edge (cnt_q==N−1, where clk_q is already 0).
  - en_i=0 at that edge: go to IDLE, cnt_q=0, clk_q stays 0.
  - en_i=1 at that edge: start a new period (cnt_q=0, clk_q=1).
  - An en_i=0 pulse that is not present at a boundary is ignored.
- test_mode_i=1: clk_o=clk_i. The FSM continues to run unaffected.
- Asynchronous reset mid-period forces clk_o low immediately. A truncated high phase is permitted only on reset.

## Timing
- Enable latency: en_i high sampled at edge k gives a rising clk_o at edge k (the clk_q update). The first full period spans edges k..k+N.
- Ratio change latency: at most N_old+1 cycles from transfer to application in RUN; 1 cycle in IDLE.
- clk_o changes only on rising clk_i edges and is glitch-free by construction (a single flop output).
- Running_o rises on the IDLE→RUN edge and falls on the RUN→IDLE edge.

## Structure
- Shared package cluster_clock_pkg holds:
  - the FSM enum (IDLE, RUN)
  - the DIV_WIDTH default
  - the clamp function (N<2 → 2)
- Flat implementation; no sub-module is needed. The test-mode bypass is a single 2:1 selection at the output.

## Test plan
- Reset with DIV_INIT=2, then en_i=1 → clk_o toggles high 1 cycle / low 1 cycle; div_ready_o=1; running_o=1 one edge after en_i.
- In RUN with N=4, transfer div_i=5 mid-period → div_ready_o low until the boundary. The next period is high 3 cycles and low 2 cycles, and no period has length 4.5 or less than 4.
- div_i=0 and div_i=1 → behaves as N=2. div_i=255 → high 128 cycles, low 127 cycles.
- en_i dropped at cnt_q=1 with N=6 → the period completes (3 high, 3 low), then IDLE with clk_o=0. An en_i low pulse of one cycle mid-period → no effect.
- Transfer issued on the exact boundary edge → the ratio is applied one full period later. A second div_valid_i while pending → ignored, and the first value is applied.
- rst_i asserted while clk_o=1 → clk_o=0 immediately, all registers at reset values. test_mode_i=1 → clk_o follows clk_i cycle-exact.
